// File: rtl/ship_life_ctrl.sv
// Player ship life/respawn sequencer: explosion, blinking invulnerable respawn, game over.
// Latency: outputs registered, change on the same edge as the state; no backpressure (frame-paced).
module ship_life_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int LIFE_W         = 2,
  parameter int EXPLODE_FRAMES = 60,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_FRAMES   = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              game_start,
  input  logic              hit,
  output logic              det_clear,
  output logic [LIFE_W-1:0] lives,
  output logic              ship_visible,
  output logic              ship_exploding,
  output logic              ctrl_enable,
  output logic              game_over
);

  localparam int MAX_FRAMES = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam int BLK_W      = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0]  EXPLODE_END = CNT_W'(EXPLODE_FRAMES);
  localparam logic [CNT_W-1:0]  INVULN_END  = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [BLK_W-1:0]  BLK_LAST    = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [BLK_W-1:0]  BLK_ONE     = BLK_W'(1);
  localparam logic [LIFE_W-1:0] LIFE_START  = LIFE_W'(LIVES_INIT);
  localparam logic [LIFE_W-1:0] LIFE_ONE    = LIFE_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIVE   = 3'd1,
    EXPLODE = 3'd2,
    INVULN  = 3'd3,
    OVER    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic [BLK_W-1:0]  blink_cnt, blink_cnt_nxt;
  logic [LIFE_W-1:0] lives_nxt;
  logic              det_clear_nxt;
  logic              visible_nxt;
  logic              exploding_nxt;
  logic              ctrl_nxt;
  logic              over_nxt;
  logic              cnt_can_inc;

  // The frame counter saturates at its top value rather than wrapping.
  assign cnt_can_inc = frame_tick && (frame_cnt != {CNT_W{1'b1}});

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      frame_cnt      <= '0;
      blink_cnt      <= '0;
      lives          <= '0;
      det_clear      <= 1'b1;
      ship_visible   <= 1'b0;
      ship_exploding <= 1'b0;
      ctrl_enable    <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_cnt      <= frame_cnt_nxt;
      blink_cnt      <= blink_cnt_nxt;
      lives          <= lives_nxt;
      det_clear      <= det_clear_nxt;
      ship_visible   <= visible_nxt;
      ship_exploding <= exploding_nxt;
      ctrl_enable    <= ctrl_nxt;
      game_over      <= over_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    blink_cnt_nxt = blink_cnt;
    lives_nxt     = lives;
    det_clear_nxt = det_clear;
    visible_nxt   = ship_visible;
    exploding_nxt = ship_exploding;
    ctrl_nxt      = ctrl_enable;
    over_nxt      = game_over;

    case (state)
      IDLE, OVER: begin
        if (game_start) begin
          state_nxt     = ALIVE;
          lives_nxt     = LIFE_START;
          frame_cnt_nxt = '0;
          det_clear_nxt = 1'b0;
          visible_nxt   = 1'b1;
          exploding_nxt = 1'b0;
          ctrl_nxt      = 1'b1;
          over_nxt      = 1'b0;
        end
      end

      // hit is only looked at here; once we leave ALIVE the detector is held
      // cleared, so a lingering sticky hit cannot cost a second life.
      ALIVE: begin
        if (hit) begin
          state_nxt     = EXPLODE;
          lives_nxt     = lives - LIFE_ONE;
          frame_cnt_nxt = '0;
          det_clear_nxt = 1'b1;
          visible_nxt   = 1'b0;
          exploding_nxt = 1'b1;
          ctrl_nxt      = 1'b0;
        end
      end

      EXPLODE: begin
        if (frame_cnt == EXPLODE_END) begin
          frame_cnt_nxt = '0;
          blink_cnt_nxt = '0;
          exploding_nxt = 1'b0;
          det_clear_nxt = 1'b1;
          if (lives == '0) begin
            state_nxt   = OVER;
            visible_nxt = 1'b0;
            ctrl_nxt    = 1'b0;
            over_nxt    = 1'b1;
          end else begin
            state_nxt   = INVULN;
            visible_nxt = 1'b1;
            ctrl_nxt    = 1'b1;
          end
        end else if (cnt_can_inc) begin
          frame_cnt_nxt = frame_cnt + CNT_ONE;
        end
      end

      INVULN: begin
        if (frame_cnt == INVULN_END) begin
          state_nxt     = ALIVE;
          frame_cnt_nxt = '0;
          det_clear_nxt = 1'b0;
          visible_nxt   = 1'b1;
        end else if (cnt_can_inc) begin
          frame_cnt_nxt = frame_cnt + CNT_ONE;
          // No blink on the final frame: the ship must stay drawn into ALIVE.
          if (frame_cnt_nxt == INVULN_END) begin
            visible_nxt = 1'b1;
          end else if (blink_cnt == BLK_LAST) begin
            blink_cnt_nxt = '0;
            visible_nxt   = ~ship_visible;
          end else begin
            blink_cnt_nxt = blink_cnt + BLK_ONE;
          end
        end
      end

      default: begin
        state_nxt     = IDLE;
        frame_cnt_nxt = '0;
        blink_cnt_nxt = '0;
        lives_nxt     = '0;
        det_clear_nxt = 1'b1;
        visible_nxt   = 1'b0;
        exploding_nxt = 1'b0;
        ctrl_nxt      = 1'b0;
        over_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ship_life_ctrl.md
Name: ship_life_ctrl

Overview:
- Per-game life and respawn sequencer for the player ship.
- Consumes the sticky hit flag from the ship collision detector and re-arms that detector through its synchronous reset input.
- Counts remaining lives and sequences explosion, invulnerable respawn and game over on a per-frame time base.
- Drives ship visibility, explosion and control-enable flags to the ship drawing and ship control blocks.

Parameters:
LIVES_INIT, 3, lives loaded on game start
LIFE_W, 2, width of lives counter
EXPLODE_FRAMES, 60, frames spent in explosion
INVULN_FRAMES, 120, frames of post-respawn invulnerability
BLINK_FRAMES, 8, frames per visibility half-period during invulnerability

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-pclk pulse per frame (vsync start)
game_start  in  1  one-pclk start request
hit  in  1  ship-shot-down flag from collision detector (sticky until detector reset)
det_clear  out  1  drives collision detector reset; high = detector held cleared
lives  out  LIFE_W  remaining lives
ship_visible  out  1  draw ship sprite
ship_exploding  out  1  draw explosion sprite
ctrl_enable  out  1  ship movement/fire allowed
game_over  out  1  game over indication

Behaviour:
- States: IDLE, ALIVE, EXPLODE, INVULN, OVER. Asynchronous reset to IDLE.
- All outputs are registered and update on the same edge as the state change.
- Reset values: det_clear=1, lives=0, ship_visible=0, ship_exploding=0, ctrl_enable=0, game_over=0, frame counter=0.
- IDLE/OVER -> ALIVE on game_start:
  - lives := LIVES_INIT.
  - det_clear falls to 0 on that edge; the detector has been held cleared throughout IDLE/OVER.
- ALIVE:
  - det_clear=0, ship_visible=1, ctrl_enable=1.
  - hit=1 -> EXPLODE next edge.
  - On that edge: lives := lives-1, det_clear := 1, frame counter := 0.
  - game_start is ignored in ALIVE.
- EXPLODE:
  - ship_exploding=1, ship_visible=0, ctrl_enable=0, det_clear=1.
  - Counts frame_tick pulses. A tick coinciding with the entry edge is not counted.
  - When the count reaches EXPLODE_FRAMES, the next edge goes to OVER if lives==0, else to INVULN; counter := 0.
- INVULN:
  - det_clear=1, so hit is ignored; the detector is held cleared.
  - ctrl_enable=1.
  - ship_visible starts at 1 on entry and toggles each time the counter reaches a multiple of BLINK_FRAMES.
  - When the count reaches INVULN_FRAMES -> ALIVE: det_clear := 0, ship_visible := 1.
- OVER:
  - game_over=1, all other flags 0, det_clear=1.
  - lives holds 0.
- hit is sampled only in ALIVE. The detector's sticky output remaining high for 1-2 cycles after det_clear rises must not cause a second decrement.
- In ALIVE, hit and frame_tick in the same cycle: hit wins; the tick is not counted.
- Counter width: $clog2(max(EXPLODE_FRAMES, INVULN_FRAMES)+1). The counter saturates and never wraps.
- lives never underflows. Decrement happens only in ALIVE, and ALIVE is unreachable with lives==0 (LIVES_INIT >= 1 required).
- game_start during EXPLODE or INVULN is ignored.
- Reset asserted mid-sequence returns to IDLE immediately with reset values.

Test Plan:
Use params LIVES_INIT=3, EXPLODE_FRAMES=4, INVULN_FRAMES=6, BLINK_FRAMES=2.
- Reset then game_start pulse -> next edge: ALIVE, lives=3, det_clear=0, ship_visible=1, ctrl_enable=1, game_over=0.
- In ALIVE, hit held high for 3 cycles -> lives=2 (single decrement), ship_exploding=1, det_clear=1; after 4 frame_ticks -> INVULN, ship_exploding=0, ctrl_enable=1.
- In INVULN, 6 frame_ticks -> ship_visible sequence 1,1,0,0,1,1 per frame; hit=1 throughout has no effect on lives; after 6th tick -> ALIVE, det_clear=0.
- Three hits, each followed by full sequences -> after 3rd explosion (4 ticks) -> OVER, game_over=1, lives=0, det_clear=1; a further game_start -> ALIVE, lives=3.
- hit and frame_tick asserted in the same ALIVE cycle -> EXPLODE entered with counter 0; exactly 4 subsequent ticks are needed to leave.
- rst_n pulsed low mid-EXPLODE (asynchronously, between edges) -> outputs go to reset values immediately, state IDLE; game_start is required to resume.
